// File: rtl/udc_stream_monitor.sv
// Receive-side monitor for an up/down counter stream: reconstructs direction, captures
// reversal extremes, flags illegal steps and reports when direction tracking is stable.
module udc_stream_monitor #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned LOCK_N = 4
) (
  input  logic             clock,
  input  logic             areset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sample_en,
  output logic             dir,
  output logic             turn,
  output logic [WIDTH-1:0] peak,
  output logic [WIDTH-1:0] trough,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  typedef enum logic [1:0] {StIdle, StAcquire, StTrkUp, StTrkDn} state_e;

  localparam logic [3:0]       LockMax = 4'(LOCK_N);
  localparam logic [WIDTH-1:0] DeltaUp = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic             dir_q, dir_d;
  logic             turn_q, turn_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic [WIDTH-1:0] trough_q, trough_d;
  logic             step_err_q, step_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_hold;

  // Modular difference, so a wrap from all-ones to zero is an ordinary up step.
  assign delta   = data_in - prev_q;
  assign is_up   = (delta == DeltaUp);
  assign is_dn   = (delta == '1);
  assign is_hold = (delta == '0);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    lock_cnt_d = lock_cnt_q;
    dir_d      = dir_q;
    turn_d     = 1'b0;
    peak_d     = peak_q;
    trough_d   = trough_q;
    step_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (sample_en) begin
      prev_d = data_in;
      unique case (state_q)
        StIdle: state_d = StAcquire;
        StAcquire: begin
          if (is_up) begin
            state_d    = StTrkUp;
            dir_d      = 1'b1;
            lock_cnt_d = 4'd1;
          end else if (is_dn) begin
            state_d    = StTrkDn;
            dir_d      = 1'b0;
            lock_cnt_d = 4'd1;
          end else if (!is_hold) begin
            step_err_d = 1'b1;
          end
        end
        StTrkUp: begin
          if (is_up) begin
            if (lock_cnt_q != LockMax) lock_cnt_d = lock_cnt_q + 4'd1;
          end else if (is_dn) begin
            turn_d     = 1'b1;
            peak_d     = prev_q;
            dir_d      = 1'b0;
            state_d    = StTrkDn;
            lock_cnt_d = 4'd1;
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            state_d    = StAcquire;
            lock_cnt_d = 4'd0;
          end
        end
        StTrkDn: begin
          if (is_dn) begin
            if (lock_cnt_q != LockMax) lock_cnt_d = lock_cnt_q + 4'd1;
          end else if (is_up) begin
            turn_d     = 1'b1;
            trough_d   = prev_q;
            dir_d      = 1'b1;
            state_d    = StTrkUp;
            lock_cnt_d = 4'd1;
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            state_d    = StAcquire;
            lock_cnt_d = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (step_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);

    locked_d = (lock_cnt_d == LockMax) && ((state_d == StTrkUp) || (state_d == StTrkDn));
  end

  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      lock_cnt_q <= '0;
      dir_q      <= 1'b0;
      turn_q     <= 1'b0;
      peak_q     <= '0;
      trough_q   <= '0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      lock_cnt_q <= lock_cnt_d;
      dir_q      <= dir_d;
      turn_q     <= turn_d;
      peak_q     <= peak_d;
      trough_q   <= trough_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign dir       = dir_q;
  assign turn      = turn_q;
  assign peak      = peak_q;
  assign trough    = trough_q;
  assign step_err  = step_err_q;
  assign err_count = err_cnt_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_udc_stream_monitor.sv
// Bench for udc_stream_monitor: directed scenarios plus a random walk, all checked
// against a trend/run-length model of the counter stream.
module tb_udc_stream_monitor;

  localparam int W    = 8;
  localparam int EW   = 8;
  localparam int LN   = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic          clock, areset, sample_en;
  logic [W-1:0]  data_in;
  logic          dir, turn, step_err, locked;
  logic [W-1:0]  peak, trough;
  logic [EW-1:0] err_count;

  int n_checks = 0;
  int n_errs   = 0;

  udc_stream_monitor #(.WIDTH(W), .ERR_W(EW), .LOCK_N(LN)) dut (
    .clock     (clock),
    .areset    (areset),
    .data_in   (data_in),
    .sample_en (sample_en),
    .dir       (dir),
    .turn      (turn),
    .peak      (peak),
    .trough    (trough),
    .step_err  (step_err),
    .err_count (err_count),
    .locked    (locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: trend is +1/-1 while following a direction, 0 when none established.
  bit         m_seen;
  int         m_prev, m_trend, m_run, m_errcnt;
  bit         m_dir, m_turn, m_err, m_locked;
  logic [W-1:0] m_peak, m_trough;

  task automatic model_reset();
    m_seen = 0; m_prev = 0; m_trend = 0; m_run = 0; m_errcnt = 0;
    m_dir = 0; m_turn = 0; m_err = 0; m_locked = 0; m_peak = '0; m_trough = '0;
  endtask

  task automatic model_sample(input int v);
    int d, s;
    if (!m_seen) begin
      m_seen = 1;
      m_prev = v;
      return;
    end
    d = (v - m_prev) & MASK;
    if (d == 1 || d == MASK) begin
      s = (d == 1) ? 1 : -1;
      if (m_trend == 0) begin
        m_run = 1;
      end else if (s == m_trend) begin
        m_run = (m_run + 1 > LN) ? LN : m_run + 1;
      end else begin
        m_turn = 1;
        if (s < 0) m_peak = m_prev[W-1:0];
        else m_trough = m_prev[W-1:0];
        m_run = 1;
      end
      m_trend = s;
      m_dir = (s > 0);
    end else if (d != 0) begin
      m_err = 1;
      m_errcnt = (m_errcnt < EMAX) ? m_errcnt + 1 : EMAX;
      m_trend = 0;
      m_run = 0;
    end
    m_prev = v;
    m_locked = (m_trend != 0) && (m_run == LN);
  endtask

  task automatic drive(input int v, input bit en);
    data_in = v[W-1:0];
    sample_en = en;
    @(posedge clock);
    #1;
    m_turn = 0;
    m_err = 0;
    if (en) model_sample(v & MASK);
  endtask

  task automatic hard_reset();
    areset = 1'b0;
    sample_en = 1'b0;
    model_reset();
    @(negedge clock);
    areset = 1'b1;
  endtask

  task automatic test_reset();
    areset = 1'b0; sample_en = 1'b0; data_in = '0;
    model_reset();
    #12;
    n_checks++;
    if ({dir, turn, peak, trough, step_err, err_count, locked} !== '0) begin
      n_errs++;
      $display("FAIL reset_outputs: got dir=%0b turn=%0b peak=%0d trough=%0d err=%0b cnt=%0d lk=%0b, need all 0",
               dir, turn, peak, trough, step_err, err_count, locked);
    end
    @(negedge clock);
    areset = 1'b1;
  endtask

  task automatic test_up_lock();
    hard_reset();
    for (int v = 10; v <= 14; v++) begin
      drive(v, 1);
      n_checks++;
      if (locked !== (v == 14) || turn !== 1'b0 || step_err !== 1'b0 || err_count !== '0) begin
        n_errs++;
        $display("FAIL up_lock v=%0d: got lk=%0b turn=%0b err=%0b cnt=%0d, need lk=%0b turn=0 err=0 cnt=0",
                 v, locked, turn, step_err, err_count, v == 14);
      end
    end
    n_checks++;
    if (dir !== 1'b1) begin n_errs++; $display("FAIL up_lock_dir: got %0b need 1", dir); end
  endtask

  task automatic test_turn_peak();
    hard_reset();
    for (int v = 20; v <= 25; v++) drive(v, 1);
    n_checks++;
    if (locked !== 1'b1) begin n_errs++; $display("FAIL pre_turn_lock: got %0b need 1", locked); end
    drive(24, 1);
    n_checks++;
    if (turn !== 1'b1 || peak !== 8'd25 || dir !== 1'b0 || locked !== 1'b0) begin
      n_errs++;
      $display("FAIL turn_peak: got turn=%0b peak=%0d dir=%0b lk=%0b, need 1 25 0 0",
               turn, peak, dir, locked);
    end
    for (int v = 23; v >= 21; v--) begin
      drive(v, 1);
      n_checks++;
      if (turn !== 1'b0 || locked !== (v == 21)) begin
        n_errs++;
        $display("FAIL relock v=%0d: got turn=%0b lk=%0b, need turn=0 lk=%0b", v, turn, locked, v == 21);
      end
    end
  endtask

  task automatic test_trough_wrap();
    int seq[4] = '{254, 255, 0, 1};
    hard_reset();
    for (int v = 3; v >= 0; v--) drive(v, 1);
    drive(1, 1);
    n_checks++;
    if (turn !== 1'b1 || trough !== 8'd0 || dir !== 1'b1) begin
      n_errs++;
      $display("FAIL turn_trough: got turn=%0b trough=%0d dir=%0b, need 1 0 1", turn, trough, dir);
    end
    drive(seq[0], 1);
    n_checks++;
    if (step_err !== 1'b1 || err_count !== 8'd1) begin
      n_errs++;
      $display("FAIL resync_err: got err=%0b cnt=%0d, need 1 1", step_err, err_count);
    end
    for (int i = 1; i < 4; i++) begin
      drive(seq[i], 1);
      n_checks++;
      if (step_err !== 1'b0 || dir !== 1'b1 || turn !== 1'b0 || err_count !== 8'd1) begin
        n_errs++;
        $display("FAIL wrap v=%0d: got err=%0b dir=%0b turn=%0b cnt=%0d, need 0 1 0 1",
                 seq[i], step_err, dir, turn, err_count);
      end
    end
  endtask

  task automatic test_illegal_saturate();
    int v;
    hard_reset();
    for (int i = 46; i <= 50; i++) drive(i, 1);
    drive(60, 1);
    n_checks++;
    if (step_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      n_errs++;
      $display("FAIL illegal: got err=%0b cnt=%0d lk=%0b, need 1 1 0", step_err, err_count, locked);
    end
    drive(61, 1);
    n_checks++;
    if (dir !== 1'b1 || turn !== 1'b0 || step_err !== 1'b0 || locked !== 1'b0) begin
      n_errs++;
      $display("FAIL reacquire: got dir=%0b turn=%0b err=%0b lk=%0b, need 1 0 0 0",
               dir, turn, step_err, locked);
    end
    v = 61;
    for (int i = 0; i < 300; i++) begin
      v = (v + 3) & MASK;
      drive(v, 1);
      n_checks++;
      if (step_err !== 1'b1 || err_count !== m_errcnt[EW-1:0]) begin
        n_errs++;
        $display("FAIL err_sat i=%0d: got err=%0b cnt=%0d, need 1 %0d", i, step_err, err_count, m_errcnt);
      end
    end
    n_checks++;
    if (err_count !== 8'd255) begin n_errs++; $display("FAIL err_final: got %0d need 255", err_count); end
  endtask

  task automatic test_hold_gaps();
    hard_reset();
    for (int v = 36; v <= 40; v++) drive(v, 1);
    for (int i = 0; i < 5; i++) begin
      drive(40, 1);
      n_checks++;
      if (turn !== 1'b0 || step_err !== 1'b0 || locked !== 1'b1 || dir !== 1'b1) begin
        n_errs++;
        $display("FAIL hold i=%0d: got turn=%0b err=%0b lk=%0b dir=%0b, need 0 0 1 1",
                 i, turn, step_err, locked, dir);
      end
      drive($urandom_range(0, MASK), 0);
      n_checks++;
      if (turn !== 1'b0 || step_err !== 1'b0 || locked !== 1'b1 || dir !== 1'b1) begin
        n_errs++;
        $display("FAIL gap i=%0d: got turn=%0b err=%0b lk=%0b dir=%0b, need 0 0 1 1",
                 i, turn, step_err, locked, dir);
      end
    end
    drive(41, 1);
    n_checks++;
    if (locked !== 1'b1 || dir !== 1'b1 || turn !== 1'b0 || step_err !== 1'b0) begin
      n_errs++;
      $display("FAIL after_hold: got lk=%0b dir=%0b turn=%0b err=%0b, need 1 1 0 0",
               locked, dir, turn, step_err);
    end
  endtask

  task automatic test_async_reset();
    int seq[5] = '{100, 101, 102, 101, 120};
    hard_reset();
    for (int i = 0; i < 5; i++) drive(seq[i], 1);
    #2;
    areset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({dir, turn, peak, trough, step_err, err_count, locked} !== '0) begin
      n_errs++;
      $display("FAIL async_reset: got dir=%0b turn=%0b peak=%0d trough=%0d err=%0b cnt=%0d lk=%0b, need all 0",
               dir, turn, peak, trough, step_err, err_count, locked);
    end
    #2;
    areset = 1'b1;
    drive(7, 1);
    drive(6, 1);
    n_checks++;
    if (dir !== 1'b0 || turn !== 1'b0 || step_err !== 1'b0 || locked !== 1'b0) begin
      n_errs++;
      $display("FAIL post_reset: got dir=%0b turn=%0b err=%0b lk=%0b, need 0 0 0 0",
               dir, turn, step_err, locked);
    end
    for (int v = 5; v >= 3; v--) drive(v, 1);
    n_checks++;
    if (locked !== 1'b1 || dir !== 1'b0) begin
      n_errs++;
      $display("FAIL post_reset_lock: got lk=%0b dir=%0b, need 1 0", locked, dir);
    end
  endtask

  task automatic test_random();
    int cur, r;
    bit en;
    hard_reset();
    cur = $urandom_range(0, MASK);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      en = ($urandom_range(0, 3) != 0);
      if (en) begin
        if (r < 40) cur = (cur + 1) & MASK;
        else if (r < 70) cur = (cur - 1) & MASK;
        else if (r < 85) cur = cur;
        else cur = $urandom_range(0, MASK);
        drive(cur, 1);
      end else begin
        drive($urandom_range(0, MASK), 0);
      end
      n_checks++;
      if (dir !== m_dir || turn !== m_turn || peak !== m_peak || trough !== m_trough ||
          step_err !== m_err || err_count !== m_errcnt[EW-1:0] || locked !== m_locked) begin
        n_errs++;
        $display("FAIL random i=%0d: got dir=%0b turn=%0b pk=%0d tr=%0d err=%0b cnt=%0d lk=%0b, need %0b %0b %0d %0d %0b %0d %0b",
                 i, dir, turn, peak, trough, step_err, err_count, locked,
                 m_dir, m_turn, m_peak, m_trough, m_err, m_errcnt, m_locked);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_lock();
    test_turn_peak();
    test_trough_wrap();
    test_illegal_saturate();
    test_hold_gaps();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/udc_stream_monitor.md
Name: udc_stream_monitor

Overview:
- Receive-side companion to UpDownCounter.
- Samples the counter's data bus and reconstructs counting direction.
- Detects turnarounds and captures peak/trough values.
- Checks every step for legality and counts step errors.
- Sits at the consumer end of the counter's data interface, alongside the counter in block-level benches and the subsystem.

Parameters:
WIDTH, 8, width of observed data bus
ERR_W, 8, width of saturating error counter
LOCK_N, 4, consecutive legal non-zero steps required to assert locked (range 1..15)

Ports:
clock  input  1  single clock, rising-edge
areset  input  1  asynchronous, active-low reset
data_in  input  WIDTH  counter value under observation
sample_en  input  1  data_in is valid this cycle
dir  output  1  reconstructed direction, 1 = up, 0 = down (meaningful when locked)
turn  output  1  one-cycle pulse on a direction reversal
peak  output  WIDTH  value at the most recent up-to-down reversal
trough  output  WIDTH  value at the most recent down-to-up reversal
step_err  output  1  one-cycle pulse on an illegal step
err_count  output  ERR_W  saturating count of illegal steps
locked  output  1  direction tracking is trustworthy

Behaviour:
- Interface: one clock, named clock; reset areset is asynchronous and active-low. areset low forces, immediately and regardless of clock:
  - state IDLE; prev = 0; lock counter = 0
  - dir=0, turn=0, peak=0, trough=0, step_err=0, err_count=0, locked=0
- All outputs are registered. Effects of a sample appear on the clock edge where sample_en=1. Pulses last exactly one cycle. With sample_en=0, all state holds and pulses deassert.
- Delta is data_in - prev modulo 2^WIDTH. Classification:
  - +1: UP step. 255->0 at WIDTH=8 is UP; no special case.
  - -1 (all ones): DOWN step.
  - 0: HOLD.
  - anything else: ILLEGAL.
- prev is updated to data_in on every sample, including illegal ones.
- States:
  - IDLE: first sample loads prev, go to ACQUIRE. No other outputs change.
  - ACQUIRE:
    - UP: go to TRK_UP, dir=1, lock counter=1.
    - DOWN: go to TRK_DN, dir=0, lock counter=1.
    - HOLD: stay.
    - ILLEGAL: step_err pulse, stay.
    - No turn pulse is ever generated from ACQUIRE.
  - TRK_UP:
    - UP: stay, lock counter +1 (saturates at LOCK_N).
    - HOLD: stay, lock counter unchanged.
    - DOWN: turn pulse, peak <= prev (the old value before this sample), dir=0, go to TRK_DN, lock counter=1.
    - ILLEGAL: step_err pulse, go to ACQUIRE, lock counter=0.
  - TRK_DN: mirror of TRK_UP.
    - DOWN: stay, lock counter +1 (saturates at LOCK_N).
    - HOLD: stay, lock counter unchanged.
    - UP: turn pulse, trough <= prev, dir=1, go to TRK_UP, lock counter=1.
    - ILLEGAL: step_err pulse, go to ACQUIRE, lock counter=0.
- locked = (lock counter == LOCK_N) and state in {TRK_UP, TRK_DN}. Registered; updates on the same edge as the counter.
  - A reversal restarts the lock counter at 1, so locked drops for LOCK_N-1 samples after a turn.
- err_count increments on each step_err and saturates at 2^ERR_W-1; it never wraps.
- Simultaneous events: turn and step_err are mutually exclusive by construction.
- peak/trough hold their last captured values across ACQUIRE and until reset.
- areset asserted mid-operation returns to the full reset state. The first sample after release takes the IDLE path.

Test Plan:
1. Reset, then samples 10,11,12,13,14 -> dir=1; locked rises on the edge of sample 14 (4th UP step); turn, step_err and err_count stay 0.
2. Locked up-count 20..25, then 24 -> turn pulses one cycle; peak=25; dir=0; locked=0 until three more DOWN steps (23,22,21) relock it at 21.
3. Down-count 3,2,1,0,1 -> turn pulse; trough=0; dir=1. Then up-count 254,255,0,1 after resync -> no step_err, dir stays 1.
4. Locked up-count at 50, then sample 60 -> step_err pulse; err_count=1; locked=0; state ACQUIRE. Then 61 -> TRK_UP, no turn. Then 300 illegal jumps at ERR_W=8 -> err_count stops at 255.
5. Locked up-count, repeat value 40 for 5 samples with sample_en gaps -> no pulses; locked and dir unchanged; next 41 counts normally.
6. areset low mid-count, asynchronously between clock edges -> all outputs 0 immediately. After release, samples 7,6 -> state TRK_DN, dir=0, no turn.
